// File: rtl/tanh_forward_logic_pkg.sv
// rtl/tanh_forward_logic_pkg.sv - shared widths, tanh segment constants and latency (TANH_DERIV_EN)
package tanh_forward_logic_pkg;

    localparam int N_LEN   = 16;
    localparam int F_LEN   = 8;
    localparam int HID_DIM = 24;
    localparam int IDX_W   = $clog2(HID_DIM);

    localparam int TANH_SEG1 = 128;
    localparam int TANH_SEG2 = 256;
    localparam int TANH_SEG3 = 512;

`ifdef TANH_DERIV_EN
    localparam int LAT = HID_DIM + 5;
`else
    localparam int LAT = HID_DIM + 4;
`endif

    typedef enum logic [1:0] {SEG0, SEG1, SEG2, SEG3} seg_e;

    function automatic logic [7:0] seg_slope(input seg_e s);
        case (s)
            SEG0:    return 8'd240;
            SEG1:    return 8'd160;
            SEG2:    return 8'd48;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] seg_intercept(input seg_e s);
        case (s)
            SEG0:    return 8'd0;
            SEG1:    return 8'd40;
            SEG2:    return 8'd152;
            default: return 8'd248;
        endcase
    endfunction

endpackage

// File: rtl/tanh_forward_logic_pwl.sv
// rtl/tanh_forward_logic_pwl.sv - tanh_pwl: S1 abs/segment, S2 slope/intercept, S3 sign restore
module tanh_pwl
    import tanh_forward_logic_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             in_vld,
    input  logic [IDX_W-1:0] in_idx,
    input  logic [N_LEN-1:0] in_x,
    output logic             out_vld,
    output logic [IDX_W-1:0] out_idx,
    output logic [N_LEN-1:0] out_y
);

    logic             s1_vld, s1_sign;
    logic [IDX_W-1:0] s1_idx;
    logic [N_LEN-1:0] s1_a;
    seg_e             s1_seg;

    logic             s2_vld, s2_sign;
    logic [IDX_W-1:0] s2_idx;
    logic [N_LEN-1:0] s2_m;

    logic [N_LEN-1:0] abs_c;
    seg_e             seg_c;
    logic [31:0]      prod_c;
    logic [31:0]      m_c;

    // -32768 has no positive twin in 16 bits, so it clamps to 0x7FFF
    always_comb begin
        abs_c = in_x;
        if (in_x == 16'h8000)
            abs_c = 16'h7FFF;
        else if (in_x[N_LEN-1])
            abs_c = 16'd0 - in_x;
        if (abs_c < 16'(TANH_SEG1))
            seg_c = SEG0;
        else if (abs_c < 16'(TANH_SEG2))
            seg_c = SEG1;
        else if (abs_c < 16'(TANH_SEG3))
            seg_c = SEG2;
        else
            seg_c = SEG3;
    end

    always_comb begin
        prod_c = {16'd0, s1_a} * {24'd0, seg_slope(s1_seg)};
        m_c    = (prod_c >> F_LEN) + {24'd0, seg_intercept(s1_seg)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || !run) begin
            s1_vld  <= 1'b0;
            s1_sign <= 1'b0;
            s1_idx  <= '0;
            s1_a    <= '0;
            s1_seg  <= SEG0;
            s2_vld  <= 1'b0;
            s2_sign <= 1'b0;
            s2_idx  <= '0;
            s2_m    <= '0;
        end else begin
            s1_vld  <= in_vld;
            s1_sign <= in_x[N_LEN-1];
            s1_idx  <= in_idx;
            s1_a    <= abs_c;
            s1_seg  <= seg_c;
            s2_vld  <= s1_vld;
            s2_sign <= s1_sign;
            s2_idx  <= s1_idx;
            s2_m    <= m_c[N_LEN-1:0];
        end
    end

    assign out_vld = s2_vld;
    assign out_idx = s2_idx;
    assign out_y   = s2_sign ? (16'd0 - s2_m) : s2_m;

endmodule

// File: rtl/tanh_forward_logic.sv
// rtl/tanh_forward_logic.sv - piecewise-linear tanh over a captured hidden vector (TANH_DERIV_EN adds dq)
module tanh_forward_logic
    import tanh_forward_logic_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     run,
    output logic                     valid,
    input  logic [HID_DIM*N_LEN-1:0] d,
`ifdef TANH_DERIV_EN
    output logic [HID_DIM*N_LEN-1:0] dq,
`endif
    output logic [HID_DIM*N_LEN-1:0] q
);

    logic [7:0]       cnt;
    logic [7:0]       cnt_m1;
    logic [N_LEN-1:0] in_buf [HID_DIM];
    logic [N_LEN-1:0] q_mem  [HID_DIM];

    logic             iss_vld;
    logic [IDX_W-1:0] iss_idx;
    logic [N_LEN-1:0] iss_x;

    logic             pwl_vld;
    logic [IDX_W-1:0] pwl_idx;
    logic [N_LEN-1:0] pwl_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || !run)
            cnt <= 8'd0;
        else if (cnt != 8'(LAT))
            cnt <= cnt + 8'd1;
    end

    assign valid = run && (cnt == 8'(LAT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HID_DIM; i++)
                in_buf[i] <= '0;
        end else if (run && cnt == 8'd0) begin
            for (int i = 0; i < HID_DIM; i++)
                in_buf[i] <= d[i*N_LEN +: N_LEN];
        end
    end

    assign cnt_m1  = cnt - 8'd1;
    assign iss_vld = run && (cnt >= 8'd1) && (cnt <= 8'(HID_DIM));
    assign iss_idx = cnt_m1[IDX_W-1:0];
    assign iss_x   = iss_vld ? in_buf[iss_idx] : '0;

    tanh_pwl u_pwl (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .in_vld  (iss_vld),
        .in_idx  (iss_idx),
        .in_x    (iss_x),
        .out_vld (pwl_vld),
        .out_idx (pwl_idx),
        .out_y   (pwl_y)
    );

`ifdef TANH_DERIV_EN
    logic             s3_vld;
    logic [IDX_W-1:0] s3_idx;
    logic [N_LEN-1:0] s3_y;
    logic [31:0]      sq_c;
    logic [N_LEN-1:0] dq_c;
    logic [N_LEN-1:0] dq_mem [HID_DIM];

    assign sq_c = 32'($signed(s3_y) * $signed(s3_y));
    assign dq_c = 16'd256 - sq_c[F_LEN +: N_LEN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || !run) begin
            s3_vld <= 1'b0;
            s3_idx <= '0;
            s3_y   <= '0;
        end else begin
            s3_vld <= pwl_vld;
            s3_idx <= pwl_idx;
            s3_y   <= pwl_y;
        end
    end

    // q and dq commit together so the backward pass never sees a mismatched pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HID_DIM; i++) begin
                q_mem[i]  <= '0;
                dq_mem[i] <= '0;
            end
        end else if (run && s3_vld) begin
            q_mem[s3_idx]  <= s3_y;
            dq_mem[s3_idx] <= dq_c;
        end
    end

    for (genvar g = 0; g < HID_DIM; g++) begin : g_dq
        assign dq[g*N_LEN +: N_LEN] = dq_mem[g];
    end
`else
    // Gated by run so an abort edge never lands the in-flight element
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HID_DIM; i++)
                q_mem[i] <= '0;
        end else if (run && pwl_vld) begin
            q_mem[pwl_idx] <= pwl_y;
        end
    end
`endif

    for (genvar g = 0; g < HID_DIM; g++) begin : g_q
        assign q[g*N_LEN +: N_LEN] = q_mem[g];
    end

endmodule

// File: tb/tb_tanh_forward_logic.sv
// tb/tb_tanh_forward_logic.sv - table-driven bench for tanh_forward_logic (TANH_DERIV_EN aware)
module tb_tanh_forward_logic;

    localparam int NL = 16;
    localparam int HD = 24;
`ifdef TANH_DERIV_EN
    localparam int LATB = HD + 5;
`else
    localparam int LATB = HD + 4;
`endif

    typedef struct {
        logic [15:0] din;
        logic [15:0] exp;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             run;
    logic             valid;
    logic [HD*NL-1:0] d;
    logic [HD*NL-1:0] q;
`ifdef TANH_DERIV_EN
    logic [HD*NL-1:0] dq;
`endif

    int asserts;
    int fails;

    vec_t va [HD];
    vec_t vb [HD];

    tanh_forward_logic dut (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .valid (valid),
        .d     (d),
`ifdef TANH_DERIV_EN
        .dq    (dq),
`endif
        .q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %0d (0x%h) expected %0d (0x%h)", name, idx,
                     $signed(act), act, $signed(exp), exp);
        end
    endtask

    function automatic logic [15:0] qw(input int i);
        return q[i*NL +: NL];
    endfunction

    task automatic load(input vec_t v [HD]);
        for (int i = 0; i < HD; i++)
            d[i*NL +: NL] = v[i].din;
    endtask

    initial begin
        int da [9];
        int ea [9];
        int pb [8];
        int eb [8];
        int nwr;
        da = '{0, 64, -64, 128, 256, -384, 512, 32767, -32768};
        ea = '{0, 60, -60, 120, 200, -224, 248, 248, -248};
        pb = '{100, -200, 300, 1000, -1, 127, -255, 511};
        eb = '{93, -165, 208, 248, 0, 119, -199, 247};
        for (int i = 0; i < HD; i++) begin
            va[i].din = (i < 9) ? 16'(da[i]) : 16'd0;
            va[i].exp = (i < 9) ? 16'(ea[i]) : 16'd0;
            vb[i].din = 16'(pb[i % 8]);
            vb[i].exp = 16'(eb[i % 8]);
        end
        asserts = 0;
        fails   = 0;
        nwr     = 10 - (LATB - HD);

        rst_n = 1'b0;
        run   = 1'b0;
        d     = '0;
        #3;
        check("reset_valid", 0, {15'd0, valid}, 16'd0);
        check("reset_q", 0, qw(0), 16'd0);
        tick(2);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            check("idle_valid", k, {15'd0, valid}, 16'd0);
        end
        for (int i = 0; i < HD; i++)
            check("idle_q", i, qw(i), 16'd0);

        // Basic vector A
        load(va);
        run = 1'b1;
        tick(LATB - 1);
        check("basic_valid_early", LATB - 1, {15'd0, valid}, 16'd0);
        tick(1);
        check("basic_valid", LATB, {15'd0, valid}, 16'd1);
        for (int i = 0; i < HD; i++)
            check("basic_q", i, qw(i), va[i].exp);
        tick(3);
        check("basic_valid_hold", 0, {15'd0, valid}, 16'd1);
        check("basic_q_hold", 5, qw(5), va[5].exp);
        run = 1'b0;
        #1;
        check("runlow_valid", 0, {15'd0, valid}, 16'd0);
        tick(1);
        check("runlow_q_keep", 8, qw(8), va[8].exp);

        // Abort with vector B after 9 edges of run
        load(vb);
        run = 1'b1;
        tick(9);
        run = 1'b0;
        tick(1);
        check("abort_valid", 0, {15'd0, valid}, 16'd0);
        for (int i = 0; i < HD; i++)
            check("abort_q", i, qw(i), (i < nwr) ? vb[i].exp : va[i].exp);

        // Rerun with B; d changes after the capture edge must be ignored
        run = 1'b1;
        tick(1);
        d = {HD{16'h7FFF}};
        tick(LATB - 1);
        check("rerun_valid", 0, {15'd0, valid}, 16'd1);
        for (int i = 0; i < HD; i++)
            check("capture_q", i, qw(i), vb[i].exp);
        run = 1'b0;
        tick(1);

        // Async reset mid-operation
        load(va);
        run = 1'b1;
        tick(15);
        rst_n = 1'b0;
        #1;
        check("areset_valid", 0, {15'd0, valid}, 16'd0);
        for (int i = 0; i < HD; i += 5)
            check("areset_q", i, qw(i), 16'd0);
        run = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        run = 1'b1;
        tick(LATB);
        check("post_reset_valid", 0, {15'd0, valid}, 16'd1);
        for (int i = 0; i < HD; i++)
            check("post_reset_q", i, qw(i), va[i].exp);
        run = 1'b0;
        tick(1);

`ifdef TANH_DERIV_EN
        d = '0;
        d[0*NL +: NL] = 16'd256;
        d[2*NL +: NL] = 16'hFF00;
        run = 1'b1;
        tick(LATB - 1);
        check("deriv_valid_early", 0, {15'd0, valid}, 16'd0);
        tick(1);
        check("deriv_valid", 0, {15'd0, valid}, 16'd1);
        check("deriv_q", 0, qw(0), 16'd200);
        check("deriv_dq", 0, dq[0*NL +: NL], 16'd100);
        check("deriv_dq", 1, dq[1*NL +: NL], 16'd256);
        check("deriv_q", 2, qw(2), 16'hFF38);
        check("deriv_dq", 2, dq[2*NL +: NL], 16'd100);
        run = 1'b0;
        tick(1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
